// File: rtl/jpeg_pkg.sv
// Shared types, constants and the magnitude-category helper for the JPEG run-length stage.
// The symbol struct is sized for the default 15-bit coefficient / 5-bit category configuration.
package jpeg_pkg;

    localparam int COEF_COUNT = 64;
    localparam int SYM_DATA_W = 15;
    localparam int SYM_SIZE_W = 5;
    localparam logic [3:0] ZRL_RUN = 4'd15;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } rle_state_t;

    typedef struct packed {
        logic [3:0]            run;
        logic [SYM_SIZE_W-1:0] size;
        logic [SYM_DATA_W:0]   amp;
        logic                  is_dc;
        logic                  last;
    } rle_symbol_t;

    localparam rle_symbol_t EOB_SYMBOL = '{run: 4'd0, size: '0, amp: '0, is_dc: 1'b0, last: 1'b1};
    localparam rle_symbol_t ZRL_SYMBOL = '{run: ZRL_RUN, size: '0, amp: '0, is_dc: 1'b0, last: 1'b0};

    // Bit length of an unsigned magnitude; 0 maps to 0.
    function automatic int size_category(input logic [31:0] mag);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) c = i + 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/jpeg_size_category.sv
// Combinational JPEG magnitude category of a signed two's-complement value of width W.
module jpeg_size_category
    import jpeg_pkg::*;
#(
    parameter int W      = 16,
    parameter int SIZE_W = 5
) (
    input  logic signed [W-1:0]      value_i,
    output logic        [SIZE_W-1:0] cat_o
);

    logic [W-1:0]  mag;
    logic [31:0]   mag_ext;

    // The most negative input negates to itself, which read as unsigned is the correct magnitude.
    always_comb begin
        mag     = value_i[W-1] ? -value_i : value_i;
        mag_ext = 32'(mag);
        cat_o   = SIZE_W'(size_category(mag_ext));
    end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// Turns one zigzag-ordered quantized 8x8 block into JPEG (run, size, amplitude) symbols:
// a DC-difference symbol against the channel predictor, then AC symbols with ZRL/EOB.
//
// state | meaning
// IDLE  | waiting for a block; capture loads the DC symbol and updates the predictor
// SCAN  | walking coefficients 1..63, one per cycle, emitting AC/ZRL/EOB symbols
module jpeg_rle_encoder
    import jpeg_pkg::*;
#(
    parameter int DATA_WIDTH  = 15,
    parameter int PIXEL_COUNT = 64,
    parameter int SIZE_W      = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] in_block,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              dc_clear,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [3:0]                        out_run,
    output logic [SIZE_W-1:0]                 out_size,
    output logic [DATA_WIDTH:0]               out_amp,
    output logic                              out_is_dc,
    output logic                              out_last
);

    rle_state_t             state_q, state_d;
    rle_symbol_t            sym_q, sym_d;
    logic                   valid_q, valid_d;
    logic [5:0]             k_q, k_d;
    logic [3:0]             run_q, run_d;
    logic [DATA_WIDTH-1:0]  pred_q, pred_d;
    logic [COEF_COUNT-1:1]  nz_q, nz_d;
    logic [DATA_WIDTH-1:0]  coef_q [1:COEF_COUNT-1];

    logic                   slot_free, capture;
    logic [DATA_WIDTH-1:0]  coef0, pred_eff, coef_k;
    logic [DATA_WIDTH:0]    dc_diff;
    logic [SIZE_W-1:0]      cat_dc, cat_ac;
    logic                   coef_nz, later_nz, last_k;

    assign slot_free = !valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && !reset && slot_free;
    assign capture   = in_valid && in_ready;

    assign coef0    = in_block[DATA_WIDTH-1:0];
    assign pred_eff = dc_clear ? '0 : pred_q;
    assign dc_diff  = {coef0[DATA_WIDTH-1], coef0} - {pred_eff[DATA_WIDTH-1], pred_eff};
    assign coef_k   = coef_q[k_q];
    assign coef_nz  = nz_q[k_q];
    assign last_k   = (k_q == 6'(COEF_COUNT - 1));

    always_comb begin
        later_nz = 1'b0;
        for (int i = 1; i < COEF_COUNT; i++) begin
            if (nz_q[i] && (6'(i) > k_q)) later_nz = 1'b1;
        end
    end

    jpeg_size_category #(.W(DATA_WIDTH + 1), .SIZE_W(SIZE_W)) u_cat_dc (
        .value_i (dc_diff),
        .cat_o   (cat_dc)
    );

    jpeg_size_category #(.W(DATA_WIDTH), .SIZE_W(SIZE_W)) u_cat_ac (
        .value_i (coef_k),
        .cat_o   (cat_ac)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sym_q   <= '0;
            valid_q <= 1'b0;
            k_q     <= '0;
            run_q   <= '0;
            pred_q  <= '0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            k_q     <= k_d;
            run_q   <= run_d;
            pred_q  <= pred_d;
        end
    end

    always_ff @(posedge clk) begin
        nz_q <= nz_d;
        if (capture) begin
            for (int i = 1; i < COEF_COUNT; i++) begin
                coef_q[i] <= in_block[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_SCAN;
            ST_SCAN: if (slot_free && (coef_nz ? last_k : !later_nz)) state_d = ST_IDLE;
        endcase
    end

    // A symbol only loads when the output slot is free; otherwise the scan holds its place.
    always_comb begin
        sym_d   = sym_q;
        valid_d = valid_q && !out_ready;
        k_d     = k_q;
        run_d   = run_q;
        pred_d  = pred_eff;
        nz_d    = nz_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    sym_d   = '{run: 4'd0, size: cat_dc, amp: dc_diff, is_dc: 1'b1, last: 1'b0};
                    valid_d = 1'b1;
                    pred_d  = coef0;
                    k_d     = 6'd1;
                    run_d   = '0;
                    for (int i = 1; i < COEF_COUNT; i++) begin
                        nz_d[i] = |in_block[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            ST_SCAN: begin
                if (coef_nz) begin
                    if (slot_free) begin
                        sym_d   = '{run: run_q, size: cat_ac, amp: {coef_k[DATA_WIDTH-1], coef_k},
                                    is_dc: 1'b0, last: last_k};
                        valid_d = 1'b1;
                        run_d   = '0;
                        k_d     = last_k ? 6'd0 : k_q + 6'd1;
                    end
                end else if (!later_nz) begin
                    if (slot_free) begin
                        sym_d   = EOB_SYMBOL;
                        valid_d = 1'b1;
                        run_d   = '0;
                        k_d     = 6'd0;
                    end
                end else if (run_q == ZRL_RUN) begin
                    if (slot_free) begin
                        sym_d   = ZRL_SYMBOL;
                        valid_d = 1'b1;
                        run_d   = '0;
                        k_d     = k_q + 6'd1;
                    end
                end else begin
                    run_d = run_q + 4'd1;
                    k_d   = k_q + 6'd1;
                end
            end
        endcase
    end

    assign out_valid = valid_q;
    assign out_run   = sym_q.run;
    assign out_size  = sym_q.size;
    assign out_amp   = sym_q.amp;
    assign out_is_dc = sym_q.is_dc;
    assign out_last  = sym_q.last;

endmodule

// File: doc/jpeg_rle_encoder.md
Name: jpeg_rle_encoder

Overview:
- Downstream neighbour of the zigzag reorder stage in the JPEG compression pipeline; one instance per channel (Y, Cb or Cr).
- Accepts one quantized 8x8 block already in zigzag order.
- Emits a serial stream of JPEG (run, size, amplitude) symbols over a valid/ready handshake: one DC-difference symbol, then AC symbols with ZRL/EOB insertion.
- Maintains the per-channel DC predictor. Output feeds the Huffman entropy coder.

Parameters:
- DATA_WIDTH, 15, signed two's-complement width of each input coefficient.
- PIXEL_COUNT, 64, coefficients per block; fixed at 64, other values unsupported.
- SIZE_W, 5, width of the size-category output; must satisfy 2^SIZE_W > DATA_WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_block  input  DATA_WIDTH*PIXEL_COUNT  zigzag coefficients; index k at [k*DATA_WIDTH +: DATA_WIDTH]; k=0 is DC
- in_valid  input  1  in_block valid
- in_ready  output  1  block accepted when in_valid && in_ready
- dc_clear  input  1  pulse: reset DC predictor to 0 (restart interval)
- out_valid  output  1  symbol valid
- out_ready  input  1  symbol consumed when out_valid && out_ready
- out_run  output  4  zero run preceding the coefficient (0..15)
- out_size  output  SIZE_W  magnitude category (0 = ZRL/EOB, or DC diff of 0)
- out_amp  output  DATA_WIDTH+1  signed amplitude (DC diff or AC value), two's complement
- out_is_dc  output  1  symbol is the DC symbol
- out_last  output  1  final symbol of the block

Behaviour:
- Reset: state IDLE, out_valid=0, out_run=0, out_size=0, out_amp=0, out_is_dc=0, out_last=0, predictor=0, run counter=0, k=0.
- in_ready is combinational: state==IDLE && !reset && (!out_valid || out_ready).
- Symbol register rule: a new symbol loads only when !out_valid || out_ready. Every symbol field is held stable while out_valid && !out_ready.
- States:
  - IDLE: on capture, latch block and nonzero mask nz[63:1]. Load the DC symbol in the same edge: diff = coef0 - pred (DATA_WIDTH+1 bits), run=0, size=cat(diff), is_dc=1, last=0. Set pred <= coef0. Go to SCAN with k=1, run=0.
  - SCAN: examine coef[k] once per cycle, stalling only when a symbol must load but the slot is busy.
    - coef[k]!=0: emit (run, cat, coef sign-extended), run<=0. last=1 iff k==63; k==63 goes to IDLE.
    - coef[k]==0 and no nz bit at index >k: emit EOB (0,0,0, last=1), go to IDLE.
    - coef[k]==0, later nonzero exists, run==15: emit ZRL (15,0,0), run<=0.
    - Otherwise: run<=run+1 with no emission.
    - k increments on each consumed coefficient.
- cat(v) = bit length of |v|; cat(0)=0; max DATA_WIDTH+1.
- Latency: DC symbol valid the cycle after the input handshake. Peak throughput is one coefficient per cycle. A block takes at most 64 cycles without backpressure.
- No EOB is emitted when coef63 != 0.
- dc_clear:
  - Sets pred to 0 at the clock edge.
  - Asserted together with a capture: the captured block uses pred=0, then pred <= coef0.
  - Asserted mid-block: affects only the next block.
- Reset mid-block: abandons the block, outputs return to reset values, pred=0.
- in_valid is ignored outside IDLE.

Decomposition:
- Shared package jpeg_pkg:
  - rle_symbol_t struct {run, size, amp, is_dc, last}
  - constants ZRL_RUN=15, EOB symbol, COEF_COUNT=64
  - function size_category()
- Sub-module jpeg_size_category: combinational magnitude-to-category encoder, parameterised by width. Used twice: DC diff and AC value.

Test Plan:
- All-zero block, pred 0 -> DC(0,0,0,is_dc) then EOB(0,0,0,last); 2 symbols, out_valid on cycles 1 and 2 after handshake.
- Block coef0=5, coef1=-3, rest 0 -> DC(run0,size3,amp5); AC(0,2,-3); EOB last.
- Only coef63=1, coef0=0 -> DC(0,0,0); ZRL×3; (14,1,1,last); no EOB.
- Two blocks DC 5 then 2, no dc_clear -> second DC diff -3, size 2. Repeat with dc_clear pulsed between blocks -> diff 2, size 2.
- out_ready low 3 cycles mid-block -> symbol fields stable; in_ready=0; no symbols lost or duplicated; order preserved.
- Reset asserted at k=20 -> next cycle out_valid=0, in_ready=1. The next all-zero block yields DC diff 0 (pred cleared).
